// File: rtl/stream_sum_accumulator.sv
// Sequential front/back end for an external combinational ripple-carry adder.
// Accumulates a burst of operands and presents the sum and a sticky carry flag.
module stream_sum_accumulator #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [DATA_W-1:0] add_s,
    input  logic              add_cout,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   rem_q, rem_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len == '0) ? StDone : StAcc;
                end
            end
            StAcc: begin
                if (in_valid) begin
                    acc_d = add_s;
                    ovf_d = ovf_q | add_cout;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Start is deliberately not looked at here; only IDLE honours it.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        add_a     = acc_q;
        add_b     = (state_q == StAcc) ? in_data : '0;
        out_sum   = (state_q == StDone) ? acc_q : '0;
        out_ovf   = (state_q == StDone) ? ovf_q : 1'b0;
    end

endmodule

// File: tb/tb_stream_sum_accumulator.sv
// Bench for stream_sum_accumulator: directed scenarios plus random bursts checked
// against a plain-arithmetic model (true sum, wrap, and carry-out iff sum >= 2^16).
module tb_stream_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] add_a, add_b, add_s;
    logic        add_cout;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic        out_ready;
    logic        busy;
    logic [16:0] add_res;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // External adder model.
    assign add_res  = {1'b0, add_a} + {1'b0, add_b};
    assign add_s    = add_res[15:0];
    assign add_cout = add_res[16];

    stream_sum_accumulator #(.DATA_W(16), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf),
        .out_ready(out_ready), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete burst. spur_at: operand index at which a stray start (len=7) is
    // pulsed during ACC (-1 = none). ack_start: pulse start in the acknowledge cycle.
    task automatic run_burst(input string name, input int n, input logic [15:0] ops[$],
                             input int gaps[$], input int stall, input int spur_at,
                             input bit ack_start);
        longint      total = 0;
        logic [15:0] run = 16'h0;
        logic [15:0] exp_sum;
        logic        exp_ovf;
        tick();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || add_b !== 16'h0)
            $display("FAIL %s idle: busy=%b out_valid=%b add_b=%h want 0/0/0", name, busy, out_valid, add_b);
        else n_pass++;
        start = 1'b1; len = 8'(n);
        tick();
        start = 1'b0; len = 8'($urandom);
        n_checks++; if (busy !== 1'b1)
            $display("FAIL %s busy: got %b want 1", name, busy);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                in_valid = 1'b0; in_data = 16'($urandom);
                n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
                    $display("FAIL %s stall: in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
                else n_pass++;
                tick();
            end
            in_valid = 1'b1; in_data = ops[i];
            if (i == spur_at) begin start = 1'b1; len = 8'd7; end
            #1;
            n_checks++; if (in_ready !== 1'b1 || add_a !== run || add_b !== ops[i])
                $display("FAIL %s op%0d: in_ready=%b add_a=%h add_b=%h want 1/%h/%h",
                         name, i, in_ready, add_a, add_b, run, ops[i]);
            else n_pass++;
            total += longint'(ops[i]);
            run = run + ops[i];
            tick();
            in_valid = 1'b0; start = 1'b0;
        end
        exp_sum = run;
        exp_ovf = (total >= 65536);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL %s done: out_valid=%b in_ready=%b want 1/0", name, out_valid, in_ready);
        else n_pass++;
        n_checks++; if (out_sum !== exp_sum || out_ovf !== exp_ovf)
            $display("FAIL %s result: sum=%h ovf=%b want %h/%b", name, out_sum, out_ovf, exp_sum, exp_ovf);
        else n_pass++;
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_sum !== exp_sum || out_ovf !== exp_ovf)
                $display("FAIL %s hold%0d: valid=%b sum=%h ovf=%b want 1/%h/%b",
                         name, s, out_valid, out_sum, out_ovf, exp_sum, exp_ovf);
            else n_pass++;
        end
        out_ready = 1'b1;
        if (ack_start) begin start = 1'b1; len = 8'd2; end
        tick();
        out_ready = 1'b0; start = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s ack: out_valid=%b busy=%b want 0/0", name, out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = 8'h0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        #12;
        n_checks++; if ({in_ready, out_valid, out_sum, out_ovf, busy} !== 20'h0)
            $display("FAIL reset: rdy=%b vld=%b sum=%h ovf=%b busy=%b want all 0",
                     in_ready, out_valid, out_sum, out_ovf, busy);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] ops[$] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        int          gaps[$] = '{0, 0, 0, 0};
        run_burst("basic", 4, ops, gaps, 0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops[$] = '{16'hFFFF, 16'h0002};
        int          gaps[$] = '{0, 0};
        logic [15:0] ops1[$] = '{16'h0005};
        int          gaps1[$] = '{0};
        run_burst("wrap", 2, ops, gaps, 0, -1, 1'b0);
        run_burst("sticky_clr", 1, ops1, gaps1, 0, -1, 1'b0);
    endtask

    task automatic test_stalls();
        logic [15:0] ops[$] = '{16'h1111, 16'h2222, 16'h4444};
        int          gaps[$] = '{0, 2, 5};
        run_burst("stalls", 3, ops, gaps, 4, -1, 1'b0);
    endtask

    task automatic test_len_zero();
        logic [15:0] ops[$];
        int          gaps[$];
        run_burst("len0", 0, ops, gaps, 0, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        logic [15:0] ops[$] = '{16'h0100, 16'h0200, 16'h0300};
        int          gaps[$] = '{0, 0, 0};
        run_burst("start_in_acc", 3, ops, gaps, 0, 1, 1'b1);
        // The start pulsed during the acknowledge cycle must not open a burst.
        tick();
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL start_at_ack: busy=%b in_ready=%b want 0/0", busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] ops[$] = '{16'h1234};
        int          gaps[$] = '{0};
        tick();
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0F00 + i);
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({in_ready, out_valid, out_sum, out_ovf, busy, add_a} !== 36'h0)
            $display("FAIL async_reset: rdy=%b vld=%b sum=%h ovf=%b busy=%b add_a=%h want all 0",
                     in_ready, out_valid, out_sum, out_ovf, busy, add_a);
        else n_pass++;
        tick();
        rst = 1'b0;
        run_burst("after_reset", 1, ops, gaps, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 12; b++) begin
            logic [15:0] ops[$];
            int          gaps[$];
            int          n;
            n = (b == 11) ? 255 : int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) begin
                ops.push_back((b % 3 == 0) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                                           : 16'($urandom));
                gaps.push_back((b == 11) ? 0 : int'($urandom_range(0, 2)));
            end
            run_burst($sformatf("rand%0d", b), n, ops, gaps, int'($urandom_range(0, 3)), -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stalls();
        test_len_zero();
        test_start_ignored();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
